// File: rtl/sig_scan_detector.sv
// sig_scan_detector: scans a 1-bit RAM window and matches the bit stream
// against NUM_SIG maskable signatures in parallel.
// Ports: clk, rst (sync, active-low).
//   start/start_addr/end_addr: scan request and inclusive window.
//   sig_pat/sig_mask/sig_en/overlap_en: match configuration.
//   mem_addr/mem_rd_en/mem_dout: RAM read port, RD_LAT cycles latency.
//   busy/done: scan handshake; detect/detect_id/detect_addr: hit pulse.
//   match_cnt: per-signature saturating match counts.
module sig_scan_detector #(
  parameter int ADDR_W  = 12,
  parameter int SIG_W   = 6,
  parameter int NUM_SIG = 4,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  input  logic [NUM_SIG*SIG_W-1:0] sig_pat,
  input  logic [NUM_SIG*SIG_W-1:0] sig_mask,
  input  logic [NUM_SIG-1:0]       sig_en,
  input  logic                     overlap_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd_en,
  input  logic                     mem_dout,
  output logic                     busy,
  output logic                     done,
  output logic                     detect,
  output logic [NUM_SIG-1:0]       detect_id,
  output logic [ADDR_W-1:0]        detect_addr,
  output logic [NUM_SIG*CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int FW = $clog2(SIG_W + 1);
  localparam int DW = $clog2(RD_LAT + 2);

  state_t st, st_nx;

  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        end_q;
  logic [NUM_SIG*SIG_W-1:0] pat_q;
  logic [NUM_SIG*SIG_W-1:0] mask_q;
  logic [NUM_SIG-1:0]       en_q;
  logic                     ovl_q;
  logic [DW-1:0]            dcnt;

  // valid/address delay line aligned with mem_dout
  logic [RD_LAT-1:0]        vpipe;
  logic [ADDR_W-1:0]        apipe [RD_LAT];
  logic                     rvld;

  logic [SIG_W-1:0]         sh, sh_nx;
  logic [FW-1:0]            fill, fill_nx;
  logic [NUM_SIG-1:0]       hit;
  logic [CNT_W-1:0]         cnt [NUM_SIG];

  assign mem_addr = addr_q;
  assign rvld     = vpipe[RD_LAT-1];

  always_comb begin
    st_nx     = st;
    mem_rd_en = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (st)
      IDLE: begin
        busy = 1'b0;
        if (start) st_nx = FETCH;
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        if (addr_q == end_q) st_nx = DRAIN;
      end
      DRAIN: begin
        if (dcnt == DW'(RD_LAT)) st_nx = DONE;
      end
      DONE: begin
        done  = 1'b1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    sh_nx   = {sh[SIG_W-2:0], mem_dout};
    fill_nx = (fill == FW'(SIG_W)) ? fill : fill + 1'b1;
    hit     = '0;
    for (int k = 0; k < NUM_SIG; k++) begin
      hit[k] = rvld && en_q[k] && (fill_nx == FW'(SIG_W)) &&
               (((sh_nx ^ pat_q[k*SIG_W +: SIG_W]) &
                 mask_q[k*SIG_W +: SIG_W]) == '0);
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int k = 0; k < NUM_SIG; k++) begin
      match_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= IDLE;
      addr_q      <= '0;
      end_q       <= '0;
      pat_q       <= '0;
      mask_q      <= '0;
      en_q        <= '0;
      ovl_q       <= 1'b0;
      dcnt        <= '0;
      vpipe       <= '0;
      sh          <= '0;
      fill        <= '0;
      detect      <= 1'b0;
      detect_id   <= '0;
      detect_addr <= '0;
      for (int i = 0; i < RD_LAT; i++) apipe[i] <= '0;
      for (int k = 0; k < NUM_SIG; k++) cnt[k] <= '0;
    end else begin
      st       <= st_nx;
      vpipe[0] <= (st == FETCH);
      apipe[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        apipe[i] <= apipe[i-1];
      end

      detect <= |hit;
      if (|hit) begin
        detect_id   <= hit;
        detect_addr <= apipe[RD_LAT-1];
      end

      // without overlap a hit restarts the window from scratch
      if (rvld) begin
        sh   <= sh_nx;
        fill <= (|hit && !ovl_q) ? '0 : fill_nx;
      end

      for (int k = 0; k < NUM_SIG; k++) begin
        if (hit[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
      end

      unique case (st)
        IDLE: begin
          if (start) begin
            addr_q <= start_addr;
            end_q  <= end_addr;
            pat_q  <= sig_pat;
            mask_q <= sig_mask;
            en_q   <= sig_en;
            ovl_q  <= overlap_en;
            sh     <= '0;
            fill   <= '0;
            for (int k = 0; k < NUM_SIG; k++) cnt[k] <= '0;
          end
        end
        FETCH: begin
          addr_q <= addr_q + 1'b1;
          dcnt   <= '0;
        end
        DRAIN: dcnt <= dcnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_scan_detector.sv
// tb_sig_scan_detector: bench for sig_scan_detector with two instances,
// u_a (RD_LAT=1, CNT_W=16) and u_b (RD_LAT=3, CNT_W=2), sharing stimulus.
module tb_sig_scan_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic [11:0] end_addr = '0;
  logic [23:0] sig_pat = '0;
  logic [23:0] sig_mask = '0;
  logic [3:0]  sig_en = '0;
  logic        overlap_en = 1'b0;

  logic [11:0] mem_addr_a, mem_addr_b;
  logic        mem_rd_en_a, mem_rd_en_b;
  logic        mem_dout_a, mem_dout_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic        detect_a, detect_b;
  logic [3:0]  detect_id_a, detect_id_b;
  logic [11:0] detect_addr_a, detect_addr_b;
  logic [63:0] match_cnt_a;
  logic [7:0]  match_cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit ram [4096];
  logic       pa = 1'b0;
  logic [2:0] pb = '0;

  int ia_addr[$], ia_cyc[$], da_addr[$], da_id[$], da_cyc[$], na[$], ba[$];
  int ib_addr[$], ib_cyc[$], db_addr[$], db_id[$], db_cyc[$], nb[$], bb[$];
  int ex_addr[$], ex_id[$];
  int ex_cnt[4];

  sig_scan_detector #(.RD_LAT(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .sig_pat(sig_pat), .sig_mask(sig_mask), .sig_en(sig_en),
    .overlap_en(overlap_en),
    .mem_addr(mem_addr_a), .mem_rd_en(mem_rd_en_a),
    .mem_dout(mem_dout_a), .busy(busy_a), .done(done_a),
    .detect(detect_a), .detect_id(detect_id_a),
    .detect_addr(detect_addr_a), .match_cnt(match_cnt_a)
  );

  sig_scan_detector #(.RD_LAT(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .sig_pat(sig_pat), .sig_mask(sig_mask), .sig_en(sig_en),
    .overlap_en(overlap_en),
    .mem_addr(mem_addr_b), .mem_rd_en(mem_rd_en_b),
    .mem_dout(mem_dout_b), .busy(busy_b), .done(done_b),
    .detect(detect_b), .detect_id(detect_id_b),
    .detect_addr(detect_addr_b), .match_cnt(match_cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models with 1- and 3-cycle read latency
  always @(posedge clk) begin
    pa <= mem_rd_en_a ? ram[mem_addr_a] : 1'b0;
    pb <= {pb[1:0], mem_rd_en_b ? ram[mem_addr_b] : 1'b0};
  end
  assign mem_dout_a = pa;
  assign mem_dout_b = pb[2];

  always @(negedge clk) begin
    if (mem_rd_en_a) begin
      ia_addr.push_back(int'(mem_addr_a));
      ia_cyc.push_back(cyc);
    end
    if (detect_a) begin
      da_addr.push_back(int'(detect_addr_a));
      da_id.push_back(int'(detect_id_a));
      da_cyc.push_back(cyc);
    end
    if (done_a) na.push_back(cyc);
    if (busy_a) ba.push_back(cyc);
    if (mem_rd_en_b) begin
      ib_addr.push_back(int'(mem_addr_b));
      ib_cyc.push_back(cyc);
    end
    if (detect_b) begin
      db_addr.push_back(int'(detect_addr_b));
      db_id.push_back(int'(detect_id_b));
      db_cyc.push_back(cyc);
    end
    if (done_b) nb.push_back(cyc);
    if (busy_b) bb.push_back(cyc);
  end

  task automatic clear_q();
    ia_addr.delete(); ia_cyc.delete(); da_addr.delete();
    da_id.delete(); da_cyc.delete(); na.delete(); ba.delete();
    ib_addr.delete(); ib_cyc.delete(); db_addr.delete();
    db_id.delete(); db_cyc.delete(); nb.delete(); bb.delete();
  endtask

  task automatic run_scan(input int sa, input int ea,
                          input logic [23:0] pat,
                          input logic [23:0] mask,
                          input logic [3:0] en, input bit ovl,
                          input bit poke);
    int n;
    clear_q();
    @(negedge clk);
    start_addr = 12'(sa);
    end_addr   = 12'(ea);
    sig_pat    = pat;
    sig_mask   = mask;
    sig_en     = en;
    overlap_en = ovl;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (2) @(negedge clk);
      start_addr = 12'd100;
      end_addr   = 12'd300;
      sig_pat    = '0;
      sig_mask   = '0;
      sig_en     = '1;
      overlap_en = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while ((na.size() == 0 || nb.size() == 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL scan_timeout sa=%0d ea=%0d done_a=%0d done_b=%0d",
               sa, ea, na.size(), nb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // reference: sliding SIG_W window over the RAM window, restarting
  // after each hit when overlap is off
  function automatic void model(input int sa, input int len,
                                input logic [23:0] pat,
                                input logic [23:0] mask,
                                input logic [3:0] en, input bit ovl);
    int base;
    logic [5:0] w;
    logic [3:0] id;
    ex_addr.delete();
    ex_id.delete();
    for (int k = 0; k < 4; k++) ex_cnt[k] = 0;
    base = 0;
    for (int i = 0; i < len; i++) begin
      if (i + 1 - base >= 6) begin
        for (int j = 0; j < 6; j++)
          w[5-j] = ram[(sa + i - 5 + j) & 4095];
        id = '0;
        for (int k = 0; k < 4; k++)
          if (en[k] && ((w ^ pat[k*6 +: 6]) & mask[k*6 +: 6]) == 6'd0)
            id[k] = 1'b1;
        if (id != 4'd0) begin
          ex_addr.push_back((sa + i) & 4095);
          ex_id.push_back(int'(id));
          for (int k = 0; k < 4; k++) if (id[k]) ex_cnt[k]++;
          if (!ovl) base = i + 1;
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, detect_a, detect_id_a, detect_addr_a,
         mem_addr_a, mem_rd_en_a, match_cnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_a busy=%b done=%b det=%b addr=%0d cnt=%h exp 0",
               busy_a, done_a, detect_a, mem_addr_a, match_cnt_a);
    end
    checks++;
    if ({busy_b, done_b, detect_b, detect_id_b, detect_addr_b,
         mem_addr_b, mem_rd_en_b, match_cnt_b} !== '0) begin
      errors++;
      $display("FAIL reset_b busy=%b done=%b det=%b addr=%0d cnt=%h exp 0",
               busy_b, done_b, detect_b, mem_addr_b, match_cnt_b);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int a0, i0, t;
    for (int i = 0; i < 12; i++) ram[i] = (i == 0 || (i >= 2 && i <= 5));
    run_scan(0, 11, 24'h00002F, '1, 4'b0001, 1'b0, 1'b0);
    a0 = (da_addr.size() > 0) ? da_addr[0] : -1;
    i0 = (da_id.size() > 0) ? da_id[0] : -1;
    checks++;
    if (da_addr.size() != 1 || a0 != 5 || i0 != 1) begin
      errors++;
      $display("FAIL single_det_a n=%0d addr=%0d id=%0d exp 1/5/1",
               da_addr.size(), a0, i0);
    end
    t = (da_cyc.size() > 0 && ia_cyc.size() > 5) ?
        da_cyc[0] - ia_cyc[5] : -1;
    checks++;
    if (t != 2) begin
      errors++;
      $display("FAIL single_lat_a got %0d exp 2", t);
    end
    checks++;
    if (match_cnt_a[15:0] !== 16'd1 || na.size() != 1 ||
        ia_addr.size() != 12) begin
      errors++;
      $display("FAIL single_cnt_a cnt=%0d done=%0d reads=%0d exp 1/1/12",
               match_cnt_a[15:0], na.size(), ia_addr.size());
    end
    a0 = (db_addr.size() > 0) ? db_addr[0] : -1;
    t = (db_cyc.size() > 0 && ib_cyc.size() > 5) ?
        db_cyc[0] - ib_cyc[5] : -1;
    checks++;
    if (db_addr.size() != 1 || a0 != 5 || t != 4) begin
      errors++;
      $display("FAIL single_b n=%0d addr=%0d lat=%0d exp 1/5/4",
               db_addr.size(), a0, t);
    end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 8; i++) ram[i] = 1'b1;
    run_scan(0, 7, 24'h00003F, '1, 4'b0001, 1'b1, 1'b0);
    checks++;
    if (da_addr.size() != 3 || da_addr[0] != 5 || da_addr[2] != 7 ||
        match_cnt_a[15:0] !== 16'd3) begin
      errors++;
      $display("FAIL overlap_on n=%0d cnt=%0d exp 3/3",
               da_addr.size(), match_cnt_a[15:0]);
    end
    run_scan(0, 7, 24'h00003F, '1, 4'b0001, 1'b0, 1'b0);
    checks++;
    if (da_addr.size() != 1 || da_addr[0] != 5 ||
        match_cnt_a[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL overlap_off n=%0d cnt=%0d exp 1/1",
               da_addr.size(), match_cnt_a[15:0]);
    end
  endtask

  task automatic test_wrap();
    int ok;
    run_scan(4094, 1, 24'h00003F, '1, 4'b0001, 1'b1, 1'b0);
    ok = (ia_addr.size() == 4);
    if (ok) begin
      ok = (ia_addr[0] == 4094 && ia_addr[1] == 4095 &&
            ia_addr[2] == 0 && ia_addr[3] == 1 &&
            ia_cyc[3] - ia_cyc[0] == 3);
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL wrap_addr reads=%0d exp 4094,4095,0,1 consecutive",
               ia_addr.size());
    end
    checks++;
    if (na.size() != 1 || ba.size() == 0 || ba[$] != na[0]) begin
      errors++;
      $display("FAIL wrap_done done=%0d last_busy=%0d done_cyc=%0d",
               na.size(), (ba.size() > 0) ? ba[$] : -1,
               (na.size() > 0) ? na[0] : -1);
    end
  endtask

  task automatic test_multi_sig();
    logic [23:0] pat, mask;
    pat  = {12'h000, 6'b001111, 6'b101111};
    mask = {12'hFFF, 6'b011111, 6'b111111};
    for (int i = 0; i < 6; i++) ram[i] = (i != 1);
    run_scan(0, 5, pat, mask, 4'b0011, 1'b0, 1'b0);
    checks++;
    if (da_id.size() != 1 || da_id[0] != 3 ||
        match_cnt_a[15:0] !== 16'd1 || match_cnt_a[31:16] !== 16'd1) begin
      errors++;
      $display("FAIL multi_both n=%0d c0=%0d c1=%0d exp id 3, 1/1",
               da_id.size(), match_cnt_a[15:0], match_cnt_a[31:16]);
    end
    run_scan(0, 5, pat, mask, 4'b0010, 1'b0, 1'b0);
    checks++;
    if (da_id.size() != 1 || da_id[0] != 2 ||
        match_cnt_a[15:0] !== 16'd0 || match_cnt_a[31:16] !== 16'd1) begin
      errors++;
      $display("FAIL multi_one n=%0d c0=%0d c1=%0d exp id 2, 0/1",
               da_id.size(), match_cnt_a[15:0], match_cnt_a[31:16]);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) ram[i] = 1'b1;
    run_scan(0, 9, 24'h00003F, '1, 4'b0001, 1'b1, 1'b0);
    checks++;
    if (db_addr.size() != 5 || match_cnt_b[1:0] !== 2'd3) begin
      errors++;
      $display("FAIL sat_b n=%0d cnt=%0d exp 5/3",
               db_addr.size(), match_cnt_b[1:0]);
    end
    checks++;
    if (match_cnt_a[15:0] !== 16'd5) begin
      errors++;
      $display("FAIL sat_a cnt=%0d exp 5", match_cnt_a[15:0]);
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) ram[i] = 1'b1;
    run_scan(0, 7, 24'h00003F, '1, 4'b0001, 1'b1, 1'b1);
    checks++;
    if (da_addr.size() != 3 || match_cnt_a[15:0] !== 16'd3 ||
        ia_addr.size() != 8 || na.size() != 1 ||
        match_cnt_a[63:16] !== '0) begin
      errors++;
      $display("FAIL start_ignored n=%0d cnt=%0d reads=%0d done=%0d",
               da_addr.size(), match_cnt_a[15:0], ia_addr.size(),
               na.size());
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 31; i++) ram[i] = 1'b1;
    clear_q();
    @(negedge clk);
    start_addr = 12'd0;
    end_addr   = 12'd30;
    sig_pat    = 24'h00003F;
    sig_mask   = '1;
    sig_en     = 4'b0001;
    overlap_en = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (!busy_a || !mem_rd_en_a || match_cnt_a[15:0] == 16'd0) begin
      errors++;
      $display("FAIL abort_pre busy=%b rd=%b cnt=%0d exp busy, counting",
               busy_a, mem_rd_en_a, match_cnt_a[15:0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, mem_rd_en_a, done_a, match_cnt_a} !== '0 ||
        {busy_b, mem_rd_en_b, done_b, match_cnt_b} !== '0) begin
      errors++;
      $display("FAIL abort_rst a=%b%b%b/%h b=%b%b%b/%h exp 0",
               busy_a, mem_rd_en_a, done_a, match_cnt_a,
               busy_b, mem_rd_en_b, done_b, match_cnt_b);
    end
    rst = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (na.size() != 0 || nb.size() != 0 || busy_a || busy_b) begin
      errors++;
      $display("FAIL abort_nodone done_a=%0d done_b=%0d exp 0/0",
               na.size(), nb.size());
    end
  endtask

  task automatic test_random();
    int sa, len, bad, p;
    logic [23:0] pat, mask;
    logic [3:0] en;
    bit ovl;
    for (int it = 0; it < 15; it++) begin
      sa   = int'($urandom_range(0, 4095));
      len  = int'($urandom_range(1, 40));
      pat  = 24'($urandom);
      mask = 24'($urandom & $urandom);
      en   = 4'($urandom);
      ovl  = 1'($urandom);
      for (int i = 0; i < len; i++)
        ram[(sa + i) & 4095] = 1'($urandom);
      model(sa, len, pat, mask, en, ovl);
      run_scan(sa, (sa + len - 1) & 4095, pat, mask, en, ovl, 1'b0);

      bad = (ia_addr.size() != len || na.size() != 1);
      for (int i = 0; i < ia_addr.size() && !bad; i++)
        if (ia_addr[i] != ((sa + i) & 4095)) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand_reads it=%0d reads=%0d exp %0d done=%0d",
                 it, ia_addr.size(), len, na.size());
      end

      bad = (da_addr.size() != ex_addr.size());
      for (int j = 0; j < ex_addr.size() && !bad; j++) begin
        p = (da_addr[j] - sa) & 4095;
        if (da_addr[j] != ex_addr[j] || da_id[j] != ex_id[j] ||
            p >= ia_cyc.size() || da_cyc[j] - ia_cyc[p] != 2)
          bad = 1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand_det_a it=%0d detects=%0d exp %0d",
                 it, da_addr.size(), ex_addr.size());
      end

      bad = (db_addr.size() != ex_addr.size());
      for (int j = 0; j < ex_addr.size() && !bad; j++) begin
        p = (db_addr[j] - sa) & 4095;
        if (db_addr[j] != ex_addr[j] || db_id[j] != ex_id[j] ||
            p >= ib_cyc.size() || db_cyc[j] - ib_cyc[p] != 4)
          bad = 1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand_det_b it=%0d detects=%0d exp %0d",
                 it, db_addr.size(), ex_addr.size());
      end

      for (int k = 0; k < 4; k++) begin
        checks++;
        if (int'(match_cnt_a[k*16 +: 16]) != ex_cnt[k] ||
            int'(match_cnt_b[k*2 +: 2]) !=
              ((ex_cnt[k] > 3) ? 3 : ex_cnt[k])) begin
          errors++;
          $display("FAIL rand_cnt it=%0d k=%0d a=%0d b=%0d exp %0d",
                   it, k, match_cnt_a[k*16 +: 16],
                   match_cnt_b[k*2 +: 2], ex_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_wrap();
    test_multi_sig();
    test_saturate();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
